gfx_plane_shifter: RTL

- Parametrised successor to the playfield/motion-object graphic shifter stage.
- Accepts one graphic ROM fetch (PLANES bit-planes of PIX pixels each) per load, with per-load flip, palette and per-plane ROM/fill select.
- Serialises pixels for CHANNELS independent channels (e.g. PF and MO). Each channel has an active shifter plus a one-deep pending buffer, so back-to-back words stream without gaps.
- Sits between the graphic ROM banks and the colour/priority logic.

---
 rtl/gfx_plane_shifter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gfx_plane_shifter.sv
// Multi-channel graphic plane shifter: ROM word (or fill) in, one pixel per shift out.
// Optional colour-0 transparency flag output enabled by defining GFX_TRANSPARENT_EN.
module gfx_plane_shifter #(
  parameter int PLANES   = 6,
  parameter int PIX      = 8,
  parameter int CHANNELS = 2,
  parameter int PAL_W    = 2,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             sysclk,
  input  logic                             reset_b,
  input  logic [PLANES*PIX-1:0]            rom_data,
  input  logic                             ld_valid,
  input  logic [CW-1:0]                    ld_ch,
  input  logic                             ld_flip,
  input  logic [PAL_W-1:0]                 ld_pal,
  input  logic [PLANES-1:0]                ld_rom_sel,
  input  logic [PLANES-1:0]                ld_fill,
  output logic                             ld_ready,
  input  logic [CHANNELS-1:0]              shift_en,
  output logic [CHANNELS*(PAL_W+PLANES)-1:0] pix,
  output logic [CHANNELS-1:0]              pix_valid,
  output logic [CHANNELS-1:0]              underrun,
  input  logic                             clr_underrun
`ifdef GFX_TRANSPARENT_EN
  ,
  output logic [CHANNELS-1:0]              pix_opaque
`endif
);

  localparam int WORD_W = PLANES * PIX;
  localparam int PW     = PAL_W + PLANES;
  localparam int CNT_W  = $clog2(PIX);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

  logic [WORD_W-1:0]     ld_word;
  logic [CHANNELS-1:0]   full_vec;
  logic [(1<<CW)-1:0]    ready_vec;

  // Head bit of every plane for a given word, direction and pixel count.
  function automatic logic [PLANES-1:0] head_bits(input logic [WORD_W-1:0] w,
                                                  input logic flip,
                                                  input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] idx;
    idx = flip ? cnt : (CNT_W'(PIX - 1) - cnt);
    for (int p = 0; p < PLANES; p++) head_bits[p] = w[p*PIX + int'(idx)];
  endfunction

  genvar gi;

  for (gi = 0; gi < PLANES; gi++) begin : g_plane
    assign ld_word[gi*PIX +: PIX] = ld_rom_sel[gi] ? rom_data[gi*PIX +: PIX] : {PIX{ld_fill[gi]}};
  end

  // Channel indices beyond CHANNELS read as never-ready so such loads are dropped.
  for (gi = 0; gi < (1 << CW); gi++) begin : g_ready
    if (gi < CHANNELS) begin : g_real
      assign ready_vec[gi] = ~full_vec[gi];
    end else begin : g_none
      assign ready_vec[gi] = 1'b0;
    end
  end

  always_comb begin
    ld_ready = ready_vec[ld_ch];
  end

  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t             state_reg, state_next;
    logic [WORD_W-1:0]  act_word_reg, act_word_next, pend_word_reg;
    logic               act_flip_reg, act_flip_next, pend_flip_reg;
    logic [PAL_W-1:0]   act_pal_reg, act_pal_next, pend_pal_reg;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]      pix_reg;
    logic [PLANES-1:0]  head_next;
    logic               underrun_reg;
    logic               valid_c, accept, shift, last, load_pend;

    assign valid_c   = (state_reg != S_EMPTY);
    assign accept    = ld_valid & ld_ready & (ld_ch == CW'(gi));
    assign shift     = shift_en[gi] & valid_c;
    assign last      = shift & (cnt_reg == CNT_W'(PIX - 1));
    assign load_pend = accept & (state_reg == S_ACTIVE) & ~last;

    always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) state_reg <= S_EMPTY;
      else          state_reg <= state_next;
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        S_EMPTY:  if (accept) state_next = S_ACTIVE;
        S_ACTIVE: begin
          if (last && !accept)      state_next = S_EMPTY;
          else if (!last && accept) state_next = S_FULL;
        end
        S_FULL:   if (last) state_next = S_ACTIVE;
        default:  state_next = S_EMPTY;
      endcase
    end

    // A new active word comes from the load port (empty or bypass) or the pending slot.
    always_comb begin
      act_word_next = act_word_reg;
      act_flip_next = act_flip_reg;
      act_pal_next  = act_pal_reg;
      cnt_next      = cnt_reg;
      if (accept && (state_reg == S_EMPTY || last)) begin
        act_word_next = ld_word;
        act_flip_next = ld_flip;
        act_pal_next  = ld_pal;
        cnt_next      = '0;
      end else if (last && state_reg == S_FULL) begin
        act_word_next = pend_word_reg;
        act_flip_next = pend_flip_reg;
        act_pal_next  = pend_pal_reg;
        cnt_next      = '0;
      end else if (shift) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
      head_next = head_bits(act_word_next, act_flip_next, cnt_next);
    end

    always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
        act_word_reg  <= '0;
        act_flip_reg  <= 1'b0;
        act_pal_reg   <= '0;
        cnt_reg       <= '0;
        pend_word_reg <= '0;
        pend_flip_reg <= 1'b0;
        pend_pal_reg  <= '0;
        pix_reg       <= '0;
        underrun_reg  <= 1'b0;
      end else begin
        act_word_reg <= act_word_next;
        act_flip_reg <= act_flip_next;
        act_pal_reg  <= act_pal_next;
        cnt_reg      <= cnt_next;
        if (load_pend) begin
          pend_word_reg <= ld_word;
          pend_flip_reg <= ld_flip;
          pend_pal_reg  <= ld_pal;
        end
        // pix keeps its last value once the channel drains.
        if (state_next != S_EMPTY) pix_reg <= {act_pal_next, head_next};
        underrun_reg <= (underrun_reg & ~clr_underrun) | (shift_en[gi] & ~valid_c);
      end
    end

`ifdef GFX_TRANSPARENT_EN
    logic opaque_reg;
    always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) opaque_reg <= 1'b0;
      else          opaque_reg <= (state_next != S_EMPTY) & (|head_next);
    end
    assign pix_opaque[gi] = opaque_reg;
`endif

    assign pix[gi*PW +: PW] = pix_reg;
    assign pix_valid[gi]    = valid_c;
    assign underrun[gi]     = underrun_reg;
    assign full_vec[gi]     = (state_reg == S_FULL);
  end

endmodule
